// File: rtl/viterbi_channel_injector_if.sv
// Symbol stream and error-injection control bundle between encoder,
// channel injector and Viterbi decoder.
interface viterbi_channel_injector_if #(
  parameter int SYM_W  = 2,
  parameter int LFSR_W = 16,
  parameter int CNT_W  = 16
);
  logic              clear_i;
  logic              valid_i;
  logic [SYM_W-1:0]  sym_i;
  logic [1:0]        mode_i;
  logic [SYM_W-1:0]  mask_i;
  logic [LFSR_W-1:0] thresh_i;
  logic [CNT_W-1:0]  gap_len_i;
  logic [CNT_W-1:0]  burst_len_i;
  logic [CNT_W-1:0]  sym_limit_i;
  logic              valid_o;
  logic [SYM_W-1:0]  sym_o;
  logic [SYM_W-1:0]  err_o;
  logic              burst_o;
  logic [CNT_W-1:0]  sym_ct_o;
  logic [CNT_W-1:0]  bit_err_ct_o;

  modport master (
    output clear_i, valid_i, sym_i, mode_i, mask_i, thresh_i,
           gap_len_i, burst_len_i, sym_limit_i,
    input  valid_o, sym_o, err_o, burst_o, sym_ct_o, bit_err_ct_o
  );

  modport slave (
    input  clear_i, valid_i, sym_i, mode_i, mask_i, thresh_i,
           gap_len_i, burst_len_i, sym_limit_i,
    output valid_o, sym_o, err_o, burst_o, sym_ct_o, bit_err_ct_o
  );
endinterface

// File: rtl/viterbi_channel_injector.sv
// Channel model: registers each coded symbol and XORs in bypass, LFSR-random,
// periodic-burst or one-shot-burst errors, counting symbols and flipped bits.
//
// state | meaning
// GAP   | clean symbols, counting up to gap_len
// BURST | hit symbols, counting up to burst_len
// DONE  | one-shot burst finished, clean until clear or mode change
module viterbi_channel_injector #(
  parameter int                SYM_W  = 2,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
  parameter int                CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  viterbi_channel_injector_if.slave bus
);
  typedef enum logic [1:0] {GAP, BURST, DONE} state_t;

  localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rc_q, rc_d;
  logic [1:0]        mode_q;
  logic [LFSR_W-1:0] lfsr_q, lfsr_next;
  logic              valid_q, burst_q;
  logic [SYM_W-1:0]  sym_q, err_q, err_d;
  logic [CNT_W-1:0]  sym_ct_q, bit_ct_q, pop;
  logic [CNT_W:0]    bit_sum, rc_inc, burst_inc;
  logic              mode_chg, go_burst, burst_hit, rand_hit, inj_en, hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= GAP;
      rc_q    <= '0;
    end else if (bus.clear_i) begin
      state_q <= GAP;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rc_d      = rc_q;
    go_burst  = 1'b0;
    burst_hit = 1'b0;
    mode_chg  = (bus.mode_i != mode_q);
    rc_inc    = {1'b0, rc_q} + ONE;
    burst_inc = ((state_q == GAP) ? '0 : {1'b0, rc_q}) + ONE;
    if (bus.valid_i) begin
      if (mode_chg || !bus.mode_i[1]) begin
        state_d = GAP;
        rc_d    = '0;
      end else begin
        case (state_q)
          GAP: begin
            if (bus.gap_len_i == '0) begin
              go_burst = 1'b1;
            end else if (rc_inc >= {1'b0, bus.gap_len_i}) begin
              state_d = BURST;
              rc_d    = '0;
            end else begin
              rc_d = rc_inc[CNT_W-1:0];
            end
          end
          BURST:   go_burst = 1'b1;
          default: ;
        endcase
        // A zero-length burst is consumed in one clean step.
        if (go_burst) begin
          if (bus.burst_len_i == '0) begin
            state_d = bus.mode_i[0] ? DONE : GAP;
            rc_d    = '0;
          end else begin
            burst_hit = 1'b1;
            if (burst_inc >= {1'b0, bus.burst_len_i}) begin
              state_d = bus.mode_i[0] ? DONE : GAP;
              rc_d    = '0;
            end else begin
              state_d = BURST;
              rc_d    = burst_inc[CNT_W-1:0];
            end
          end
        end
      end
    end
  end

  always_comb begin
    lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    rand_hit  = (lfsr_q < bus.thresh_i);
    inj_en    = (bus.sym_limit_i == '0) || (sym_ct_q < bus.sym_limit_i);
    hit       = !mode_chg && inj_en &&
                ((bus.mode_i == 2'b01) ? rand_hit : burst_hit);
    err_d     = hit ? bus.mask_i : '0;
    pop       = '0;
    for (int k = 0; k < SYM_W; k++) pop = pop + CNT_W'(err_d[k]);
    bit_sum   = {1'b0, bit_ct_q} + {1'b0, pop};
  end

  // clear also adopts the current mode so the first symbol after it is not
  // mistaken for a mode change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      sym_q    <= '0;
      err_q    <= '0;
      burst_q  <= 1'b0;
      sym_ct_q <= '0;
      bit_ct_q <= '0;
      mode_q   <= 2'b00;
      lfsr_q   <= SEED;
    end else begin
      valid_q <= bus.valid_i;
      if (bus.clear_i) begin
        sym_ct_q <= '0;
        bit_ct_q <= '0;
        burst_q  <= 1'b0;
        mode_q   <= bus.mode_i;
        lfsr_q   <= SEED;
        if (bus.valid_i) begin
          sym_q <= bus.sym_i;
          err_q <= '0;
        end
      end else if (bus.valid_i) begin
        mode_q   <= bus.mode_i;
        lfsr_q   <= lfsr_next;
        sym_q    <= bus.sym_i ^ err_d;
        err_q    <= err_d;
        burst_q  <= go_burst;
        sym_ct_q <= (sym_ct_q == '1) ? sym_ct_q : sym_ct_q + 1'b1;
        bit_ct_q <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
      end
    end
  end

  assign bus.valid_o      = valid_q;
  assign bus.sym_o        = sym_q;
  assign bus.err_o        = err_q;
  assign bus.burst_o      = burst_q;
  assign bus.sym_ct_o     = sym_ct_q;
  assign bus.bit_err_ct_o = bit_ct_q;
endmodule

// File: tb/tb_viterbi_channel_injector.sv
// Randomized bench for viterbi_channel_injector: per-symbol error patterns
// come from arithmetic on symbol index and a golden LFSR sequence.
module tb_viterbi_channel_injector;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  viterbi_channel_injector_if #(.SYM_W(2), .LFSR_W(16), .CNT_W(16)) bus ();

  viterbi_channel_injector #(.SYM_W(2), .LFSR_W(16), .SEED(SEED), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Polynomial x^16+x^14+x^13+x^11+1 in right-shift Galois form.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] n;
    n = l >> 1;
    if (l[0]) n = n ^ ((16'd1 << 15) | (16'd1 << 13) | (16'd1 << 12) | (16'd1 << 10));
    return n;
  endfunction

  task automatic cycle(input logic v, input logic [1:0] s, input logic c);
    bus.valid_i = v;
    bus.sym_i   = s;
    bus.clear_i = c;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.clear_i = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] m, input logic [1:0] mask, input logic [15:0] th,
                     input logic [15:0] g, input logic [15:0] b, input logic [15:0] lim);
    bus.mode_i      = m;
    bus.mask_i      = mask;
    bus.thresh_i    = th;
    bus.gap_len_i   = g;
    bus.burst_len_i = b;
    bus.sym_limit_i = lim;
  endtask

  task automatic test_reset;
    total++;
    if ({bus.valid_o, bus.sym_o, bus.err_o, bus.burst_o, bus.sym_ct_o, bus.bit_err_ct_o} !== '0) begin
      bad++;
      $display("FAIL reset outputs: got v=%b s=%b e=%b b=%b ct=%0d bits=%0d, want all 0",
               bus.valid_o, bus.sym_o, bus.err_o, bus.burst_o, bus.sym_ct_o, bus.bit_err_ct_o);
    end
  endtask

  task automatic test_bypass;
    logic [1:0] s, last;
    cfg(2'b00, 2'b11, 16'hFFFF, 16'd0, 16'd1, 16'd0);
    cycle(1'b0, 2'b00, 1'b1);
    last = bus.sym_o;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        cycle(1'b0, 2'($urandom), 1'b0);
        total++;
        if (bus.valid_o !== 1'b0 || bus.sym_o !== last) begin
          bad++;
          $display("FAIL bypass hold i=%0d: v=%b sym=%b, want 0/%b", i, bus.valid_o, bus.sym_o, last);
        end
      end
      s = 2'($urandom);
      cycle(1'b1, s, 1'b0);
      last = s;
      total++;
      if (bus.valid_o !== 1'b1 || bus.sym_o !== s || bus.err_o !== 2'b00) begin
        bad++;
        $display("FAIL bypass sym i=%0d: v=%b sym=%b err=%b, want 1/%b/00", i, bus.valid_o, bus.sym_o, bus.err_o, s);
      end
    end
    total++;
    if (bus.sym_ct_o !== 16'd300 || bus.bit_err_ct_o !== 16'd0) begin
      bad++;
      $display("FAIL bypass counts: ct=%0d bits=%0d, want 300/0", bus.sym_ct_o, bus.bit_err_ct_o);
    end
  endtask

  task automatic test_random;
    logic [15:0] l;
    logic [1:0]  s, e;
    int          bits;
    cfg(2'b01, 2'b11, 16'h0000, 16'd0, 16'd1, 16'd0);
    cycle(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 50; i++) begin
      s = 2'($urandom);
      cycle(1'b1, s, 1'b0);
      total++;
      if (bus.err_o !== 2'b00 || bus.sym_o !== s) begin
        bad++;
        $display("FAIL random thresh0 i=%0d: err=%b sym=%b, want 00/%b", i, bus.err_o, bus.sym_o, s);
      end
    end
    for (int pass = 0; pass < 2; pass++) begin
      bus.thresh_i = (pass == 0) ? 16'hFFFF : 16'($urandom);
      cycle(1'b0, 2'b00, 1'b1);
      l = SEED;
      bits = 0;
      for (int i = 0; i < 200; i++) begin
        if (pass == 1 && $urandom_range(0, 4) == 0) cycle(1'b0, 2'b00, 1'b0);
        bus.mask_i = 2'($urandom_range(1, 3));
        s = 2'($urandom);
        e = (l < bus.thresh_i) ? bus.mask_i : 2'b00;
        bits += $countones(e);
        l = lfsr_step(l);
        cycle(1'b1, s, 1'b0);
        total++;
        if (bus.err_o !== e || bus.sym_o !== (s ^ e)) begin
          bad++;
          $display("FAIL random pass%0d i=%0d: err=%b sym=%b, want %b/%b", pass, i, bus.err_o, bus.sym_o, e, s ^ e);
        end
      end
      total++;
      if (bus.bit_err_ct_o !== 16'(bits) || bus.sym_ct_o !== 16'd200) begin
        bad++;
        $display("FAIL random counts pass%0d: bits=%0d ct=%0d, want %0d/200", pass, bus.bit_err_ct_o, bus.sym_ct_o, bits);
      end
    end
  endtask

  task automatic test_periodic;
    int         g, b, n, bits;
    logic [1:0] s, e, m;
    logic       in_b;
    for (int run = 0; run < 4; run++) begin
      if (run == 0) begin g = 3; b = 2; m = 2'b10; n = 20; end
      else begin g = $urandom_range(0, 4); b = $urandom_range(1, 4); m = 2'($urandom_range(1, 3)); n = 25; end
      cfg(2'b10, m, 16'd0, 16'(g), 16'(b), 16'd0);
      cycle(1'b0, 2'b00, 1'b1);
      bits = 0;
      for (int i = 0; i < n; i++) begin
        in_b = (i % (g + b)) >= g;
        e    = in_b ? m : 2'b00;
        bits += $countones(e);
        s = 2'($urandom);
        cycle(1'b1, s, 1'b0);
        total++;
        if (bus.err_o !== e || bus.sym_o !== (s ^ e) || bus.burst_o !== in_b) begin
          bad++;
          $display("FAIL periodic g=%0d b=%0d i=%0d: err=%b sym=%b burst=%b, want %b/%b/%b",
                   g, b, i, bus.err_o, bus.sym_o, bus.burst_o, e, s ^ e, in_b);
        end
      end
      total++;
      if (bus.bit_err_ct_o !== 16'(bits) || (run == 0 && bits != 8)) begin
        bad++;
        $display("FAIL periodic bits run%0d: got %0d, want %0d", run, bus.bit_err_ct_o, bits);
      end
    end
  endtask

  task automatic test_oneshot;
    logic [1:0] s, e;
    cfg(2'b11, 2'b11, 16'd0, 16'd5, 16'd4, 16'd0);
    for (int pass = 0; pass < 2; pass++) begin
      cycle(1'b0, 2'b00, 1'b1);
      for (int i = 0; i < 20; i++) begin
        e = (i >= 5 && i < 9) ? 2'b11 : 2'b00;
        s = 2'($urandom);
        cycle(1'b1, s, 1'b0);
        total++;
        if (bus.err_o !== e || bus.sym_o !== (s ^ e)) begin
          bad++;
          $display("FAIL oneshot pass%0d i=%0d: err=%b sym=%b, want %b/%b", pass, i, bus.err_o, bus.sym_o, e, s ^ e);
        end
      end
      total++;
      if (bus.bit_err_ct_o !== 16'd8) begin
        bad++;
        $display("FAIL oneshot bits pass%0d: got %0d, want 8", pass, bus.bit_err_ct_o);
      end
    end
  endtask

  task automatic test_limit;
    logic [1:0] s, e;
    cfg(2'b10, 2'b01, 16'd0, 16'd0, 16'd1, 16'd256);
    cycle(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 300; i++) begin
      e = (i < 256) ? 2'b01 : 2'b00;
      s = 2'($urandom);
      cycle(1'b1, s, 1'b0);
      total++;
      if (bus.err_o !== e || bus.sym_o !== (s ^ e)) begin
        bad++;
        $display("FAIL limit i=%0d: err=%b sym=%b, want %b/%b", i, bus.err_o, bus.sym_o, e, s ^ e);
      end
    end
    total++;
    if (bus.sym_ct_o !== 16'd300 || bus.bit_err_ct_o !== 16'd256) begin
      bad++;
      $display("FAIL limit counts: ct=%0d bits=%0d, want 300/256", bus.sym_ct_o, bus.bit_err_ct_o);
    end
  endtask

  task automatic test_mode_change;
    logic [1:0] s, e;
    cfg(2'b10, 2'b11, 16'd0, 16'd2, 16'd2, 16'd0);
    cycle(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      e = (i == 2) ? 2'b11 : 2'b00;
      s = 2'($urandom);
      cycle(1'b1, s, 1'b0);
      total++;
      if (bus.err_o !== e) begin
        bad++;
        $display("FAIL modechg pre i=%0d: err=%b, want %b", i, bus.err_o, e);
      end
    end
    bus.mode_i = 2'b11;
    for (int j = -1; j < 8; j++) begin
      e = (j == 2 || j == 3) ? 2'b11 : 2'b00;
      s = 2'($urandom);
      cycle(1'b1, s, 1'b0);
      total++;
      if (bus.err_o !== e || bus.sym_o !== (s ^ e)) begin
        bad++;
        $display("FAIL modechg post j=%0d: err=%b sym=%b, want %b/%b", j, bus.err_o, bus.sym_o, e, s ^ e);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [1:0] s, e;
    cfg(2'b10, 2'b11, 16'd0, 16'd1, 16'd5, 16'd0);
    cycle(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'($urandom), 1'b0);
    total++;
    if (bus.err_o !== 2'b11 || bus.burst_o !== 1'b1) begin
      bad++;
      $display("FAIL areset midburst: err=%b burst=%b, want 11/1", bus.err_o, bus.burst_o);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({bus.valid_o, bus.sym_o, bus.err_o, bus.burst_o, bus.sym_ct_o, bus.bit_err_ct_o} !== '0) begin
      bad++;
      $display("FAIL areset immediate: v=%b s=%b e=%b b=%b ct=%0d bits=%0d, want all 0",
               bus.valid_o, bus.sym_o, bus.err_o, bus.burst_o, bus.sym_ct_o, bus.bit_err_ct_o);
    end
    @(negedge clk);
    rst = 1'b1;
    // Registered mode is 00 after reset, so the first symbol is a mode change.
    for (int i = 0; i < 8; i++) begin
      e = (i >= 2 && i <= 6) ? 2'b11 : 2'b00;
      s = 2'($urandom);
      cycle(1'b1, s, 1'b0);
      total++;
      if (bus.err_o !== e || bus.sym_o !== (s ^ e)) begin
        bad++;
        $display("FAIL areset restart i=%0d: err=%b sym=%b, want %b/%b", i, bus.err_o, bus.sym_o, e, s ^ e);
      end
    end
  endtask

  task automatic test_clear_valid;
    logic [1:0] s;
    cfg(2'b10, 2'b11, 16'd0, 16'd0, 16'd1, 16'd0);
    cycle(1'b0, 2'b00, 1'b1);
    cycle(1'b1, 2'b01, 1'b0);
    cycle(1'b1, 2'b10, 1'b0);
    s = 2'($urandom);
    cycle(1'b1, s, 1'b1);
    total++;
    if (bus.valid_o !== 1'b1 || bus.sym_o !== s || bus.err_o !== 2'b00 ||
        bus.sym_ct_o !== 16'd0 || bus.bit_err_ct_o !== 16'd0) begin
      bad++;
      $display("FAIL clear+valid: v=%b sym=%b err=%b ct=%0d bits=%0d, want 1/%b/00/0/0",
               bus.valid_o, bus.sym_o, bus.err_o, bus.sym_ct_o, bus.bit_err_ct_o, s);
    end
    s = 2'($urandom);
    cycle(1'b1, s, 1'b0);
    total++;
    if (bus.err_o !== 2'b11 || bus.sym_ct_o !== 16'd1 || bus.bit_err_ct_o !== 16'd2) begin
      bad++;
      $display("FAIL after clear: err=%b ct=%0d bits=%0d, want 11/1/2", bus.err_o, bus.sym_ct_o, bus.bit_err_ct_o);
    end
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.clear_i = 1'b0;
    bus.sym_i   = 2'b00;
    cfg(2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
    #12;
    test_reset;
    @(negedge clk);
    rst = 1'b1;
    test_bypass;
    test_random;
    test_periodic;
    test_oneshot;
    test_limit;
    test_mode_change;
    test_async_reset;
    test_clear_valid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
